// File: rtl/axi_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem_pkg
//  Description : Shared AXI4 types and codes for the axi_slave_mem slice:
//                address/data/length types, size/burst/response encodings
//                and the slave FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_slave_mem_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [7:0]  len_t;

  localparam logic [2:0] SIZE_4_BYTE = 3'b010;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  localparam int WORD_BYTES = 4;

  // Slave FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RDATA = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_WRESP = 2'd3;

endpackage

`default_nettype wire

// File: rtl/axi_slave_mem_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_addr_gen
//  Description : Combinational AXI beat address generator. Produces the
//                address of the following beat and flags burst types or beat
//                sizes this slave does not service.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_addr_gen
  import axi_slave_mem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  burst,
  input  logic [2:0]  size,
  output logic [31:0] next_addr,
  output logic        unsupported
);

  // Only full-word INCR and FIXED bursts are serviced; everything else errors.
  always_comb begin
    unsupported = (size != SIZE_4_BYTE) ||
                  !((burst == BURST_INCR) || (burst == BURST_FIXED));
    next_addr   = (burst == BURST_INCR) ? (addr + 32'(WORD_BYTES)) : addr;
  end

endmodule

`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem
//  Description : AXI4 slave backed by a DEPTH x 32-bit word RAM. Services one
//                burst at a time (read AR->R or write AW->W->B), INCR/FIXED.
//                Optional macro AXI_SLAVE_MEM_BACKPRESSURE_EN throttles wready
//                on alternate cycles and inserts a bubble after each R beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH * WORD_BYTES);

  logic [1:0] state_q, state_d;
  addr_t      addr_q, addr_d;
  len_t       len_q, len_d;
  logic [1:0] burst_q, burst_d;
  logic [2:0] size_q, size_d;
  logic [8:0] beat_cnt_q, beat_cnt_d;
  logic       werr_q, werr_d;
  data_t      rdata_q, rdata_d;
  resp_t      rresp_q, rresp_d;
  logic       rlast_q, rlast_d;
  logic       rvalid_q, rvalid_d;
  resp_t      bresp_q, bresp_d;
  logic       bvalid_q, bvalid_d;
  logic       ready_en_q, ready_en_d;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
  logic       toggle_q, toggle_d;
`endif

  data_t      mem_q [DEPTH];

  logic [1:0] gen_burst;
  logic [2:0] gen_size;
  addr_t      gen_next;
  logic       gen_unsup;

  addr_t      look_addr, look_off, cur_off;
  logic       look_in, cur_in, beat_ok, w_over, mem_we;
  logic [IDX_W-1:0] look_idx, cur_idx;
  logic       ar_hs, aw_hs, r_hs, w_hs, b_hs;

  // In IDLE the generator judges the incoming request; otherwise the latched burst.
  always_comb begin
    gen_burst = burst_q;
    gen_size  = size_q;
    if (state_q == ST_IDLE) begin
      gen_burst = s_axi_arvalid ? s_axi_arburst : s_axi_awburst;
      gen_size  = s_axi_arvalid ? s_axi_arsize  : s_axi_awsize;
    end
  end

  axi_addr_gen u_addr_gen (
    .addr        (addr_q),
    .burst       (gen_burst),
    .size        (gen_size),
    .next_addr   (gen_next),
    .unsupported (gen_unsup)
  );

  // Address decode: read lookahead targets the beat about to be presented,
  // write decode targets the beat currently on the W channel.
  always_comb begin
    look_addr = (state_q == ST_IDLE) ? s_axi_araddr : gen_next;
    look_off  = look_addr - BASE_ADDR;
    look_in   = look_off < SPAN;
    look_idx  = look_off[IDX_W+1:2];
    cur_off   = addr_q - BASE_ADDR;
    cur_in    = cur_off < SPAN;
    cur_idx   = cur_off[IDX_W+1:2];
    beat_ok   = look_in && !gen_unsup;
    w_over    = beat_cnt_q > {1'b0, len_q};
    ar_hs     = s_axi_arvalid && s_axi_arready;
    aw_hs     = s_axi_awvalid && s_axi_awready;
    r_hs      = rvalid_q && s_axi_rready;
    w_hs      = s_axi_wvalid && s_axi_wready;
    b_hs      = bvalid_q && s_axi_bready;
    mem_we    = areset_n && (state_q == ST_WDATA) && w_hs &&
                !w_over && cur_in && !gen_unsup;
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!areset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic; a read request wins over a simultaneous write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs) state_d = ST_RDATA;
                else if (aw_hs) state_d = ST_WDATA;
      ST_RDATA: if (r_hs && rlast_q) state_d = ST_IDLE;
      ST_WDATA: if (w_hs && s_axi_wlast) state_d = ST_WRESP;
      ST_WRESP: if (b_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready strobes, held low until the first cycle after reset
  always_comb begin
    s_axi_arready = ready_en_q && (state_q == ST_IDLE);
    s_axi_awready = ready_en_q && (state_q == ST_IDLE) && !s_axi_arvalid;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
    s_axi_wready  = ready_en_q && (state_q == ST_WDATA) && !toggle_q;
`else
    s_axi_wready  = ready_en_q && (state_q == ST_WDATA);
`endif
    s_axi_rdata   = rdata_q;
    s_axi_rresp   = rresp_q;
    s_axi_rlast   = rlast_q;
    s_axi_rvalid  = rvalid_q;
    s_axi_bresp   = bresp_q;
    s_axi_bvalid  = bvalid_q;
  end

  // Burst bookkeeping and registered R/B channel contents
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    size_d     = size_q;
    beat_cnt_d = beat_cnt_q;
    werr_d     = werr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    bresp_d    = bresp_q;
    bvalid_d   = bvalid_q;
    ready_en_d = 1'b1;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
    toggle_d   = ~toggle_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d     = s_axi_araddr;
          len_d      = s_axi_arlen;
          burst_d    = s_axi_arburst;
          size_d     = s_axi_arsize;
          beat_cnt_d = 9'd0;
          rvalid_d   = 1'b1;
          rlast_d    = (s_axi_arlen == 8'd0);
          rdata_d    = beat_ok ? mem_q[look_idx] : 32'h0;
          rresp_d    = beat_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (aw_hs) begin
          addr_d     = s_axi_awaddr;
          len_d      = s_axi_awlen;
          burst_d    = s_axi_awburst;
          size_d     = s_axi_awsize;
          beat_cnt_d = 9'd0;
          werr_d     = gen_unsup;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            addr_d     = gen_next;
            beat_cnt_d = beat_cnt_q + 9'd1;
            rlast_d    = ((beat_cnt_q + 9'd1) == {1'b0, len_q});
            rdata_d    = beat_ok ? mem_q[look_idx] : 32'h0;
            rresp_d    = beat_ok ? RESP_OKAY : RESP_SLVERR;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
            rvalid_d   = 1'b0;
`else
            rvalid_d   = 1'b1;
`endif
          end
        end
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
        else if (!rvalid_q) begin
          rvalid_d = 1'b1;
        end
`endif
      end
      ST_WDATA: begin
        if (w_hs) begin
          // Saturate so runaway bursts stay flagged as overlong
          beat_cnt_d = (beat_cnt_q == 9'h1FF) ? beat_cnt_q : beat_cnt_q + 9'd1;
          addr_d     = gen_next;
          if (w_over || !cur_in || gen_unsup) werr_d = 1'b1;
          if (s_axi_wlast && (beat_cnt_q != {1'b0, len_q})) werr_d = 1'b1;
          if (s_axi_wlast) begin
            bvalid_d = 1'b1;
            bresp_d  = werr_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_WRESP: begin
        if (b_hs) bvalid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any burst without a response
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      beat_cnt_q <= '0;
      werr_q     <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
      ready_en_q <= 1'b0;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
      toggle_q   <= 1'b0;
`endif
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
      beat_cnt_q <= beat_cnt_d;
      werr_q     <= werr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
      ready_en_q <= ready_en_d;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
      toggle_q   <= toggle_d;
`endif
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (s_axi_wstrb[b]) mem_q[cur_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire
